// File: rtl/pc_fetch_seq.sv
// Program-counter / fetch sequencer with relative branches, jumps,
// a return-address stack and a boot/run/halt/fault state machine.
module pc_fetch_seq #(
  parameter int                ADDR_W    = 8,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           halt,
  input  logic                           resume,
  input  logic                           br_en,
  input  logic [1:0]                     br_mode,
  input  logic                           lt_flag,
  input  logic                           eq_flag,
  input  logic [ADDR_W-1:0]              br_off,
  input  logic                           jmp_en,
  input  logic                           call_en,
  input  logic                           ret_en,
  input  logic [ADDR_W-1:0]              jmp_addr,
  output logic [ADDR_W-1:0]              pc,
  output logic                           pc_valid,
  output logic [1:0]                     state,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_depth,
  output logic                           fault_ovf,
  output logic                           fault_unf
);

  localparam int DW = $clog2(RAS_DEPTH + 1);
  localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [1:0] S_BOOT  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_HALT  = 2'b10;
  localparam logic [1:0] S_FAULT = 2'b11;

  localparam logic [DW-1:0] FULL = DW'(RAS_DEPTH);
  localparam logic [DW-1:0] ONE  = DW'(1);

  logic [ADDR_W-1:0] ras [RAS_DEPTH];

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [1:0]        state_d;
  logic [DW-1:0]     depth_d;
  logic              ovf_d;
  logic              unf_d;
  logic              push;
  logic              taken;
  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     push_idx;

  assign pc_inc   = pc + ADDR_W'(1);
  assign top_idx  = IW'(ras_depth - ONE);
  assign push_idx = IW'(ras_depth);
  assign pc_valid = (state == S_RUN);

  always_comb begin
    taken = 1'b0;
    unique case (br_mode)
      2'b00: taken = lt_flag;
      2'b01: taken = !eq_flag;
      2'b10: taken = eq_flag;
      2'b11: taken = !lt_flag;
    endcase
  end

  // Control priority: halt > ret > call > jmp > branch > sequential
  always_comb begin
    pc_d    = pc;
    state_d = state;
    depth_d = ras_depth;
    ovf_d   = fault_ovf;
    unf_d   = fault_unf;
    push    = 1'b0;
    unique case (state)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (ret_en) begin
          if (ras_depth == '0) begin
            unf_d   = 1'b1;
            state_d = S_FAULT;
          end else begin
            pc_d    = ras[top_idx];
            depth_d = ras_depth - ONE;
          end
        end else if (call_en) begin
          if (ras_depth == FULL) begin
            ovf_d   = 1'b1;
            state_d = S_FAULT;
          end else begin
            push    = 1'b1;
            pc_d    = jmp_addr;
            depth_d = ras_depth + ONE;
          end
        end else if (jmp_en) begin
          pc_d = jmp_addr;
        end else if (br_en && taken) begin
          pc_d = pc + br_off;
        end else begin
          pc_d = pc_inc;
        end
      end
      S_HALT: begin
        if (resume && !halt) state_d = S_RUN;
      end
      S_FAULT: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_VEC;
      state     <= S_BOOT;
      ras_depth <= '0;
      fault_ovf <= 1'b0;
      fault_unf <= 1'b0;
    end else begin
      pc        <= pc_d;
      state     <= state_d;
      ras_depth <= depth_d;
      fault_ovf <= ovf_d;
      fault_unf <= unf_d;
    end
  end

  // Stack storage is never cleared; only entries below ras_depth matter
  always_ff @(posedge clk) begin
    if (push) ras[push_idx] <= pc_inc;
  end

endmodule
